arbitro_alu: RTL and testbench

//  Shares the single ALU between two requesters (0: main datapath, 1: auxiliary unit).

---
 rtl/arbitro_alu_if.sv | 40 ++++
 rtl/arbitro_alu.sv | 158 +++++++++++++++
 tb/tb_arbitro_alu.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_alu_if.sv
// Requester-side bundle for arbitro_alu: two request channels, two response
// channels and the shared response data. master = requesters, slave = arbiter.
interface arbitro_alu_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              resp0_valid;
    logic              resp0_ready;
    logic              resp1_valid;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp_resultado;
    logic              resp_desvio;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_resultado, resp_desvio
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_resultado, resp_desvio
    );
endinterface

// File: rtl/arbitro_alu.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Optional grant counters enabled by defining ARBITRO_ALU_CONTADORES_EN.
module arbitro_alu #(
    parameter int DATA_W   = 32,
    parameter int LATENCIA = 1
) (
    input  logic              clock,
    input  logic              reset,
    arbitro_alu_if.slave      bus,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] alu_valor1,
    output logic [DATA_W-1:0] alu_valor2,
    input  logic [DATA_W-1:0] alu_resultado,
    input  logic              alu_desvio
`ifdef ARBITRO_ALU_CONTADORES_EN
    ,
    output logic [15:0]       cont_grant0,
    output logic [15:0]       cont_grant1
`endif
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    localparam int         CW     = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
    localparam logic [3:0] OP_NOP = 4'b1111;

    estado_t           estado_q, estado_d;
    logic [CW-1:0]     contador_q, contador_d;
    logic              dono_q, dono_d;
    logic              ultimo_q, ultimo_d;
    logic [3:0]        control_q, control_d;
    logic [DATA_W-1:0] valor1_q, valor1_d;
    logic [DATA_W-1:0] valor2_q, valor2_d;
    logic [DATA_W-1:0] resultado_q, resultado_d;
    logic              desvio_q, desvio_d;

    logic grant;
    logic grant_vld;
    logic aceite0;
    logic aceite1;
    logic resp_ready_dono;

    // On a tie the grant goes to whoever was not served last.
    always_comb begin
        grant_vld = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~ultimo_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign bus.req0_ready = !reset && (estado_q == OCIOSO) && grant_vld && !grant;
    assign bus.req1_ready = !reset && (estado_q == OCIOSO) && grant_vld && grant;
    assign aceite0        = bus.req0_valid && bus.req0_ready;
    assign aceite1        = bus.req1_valid && bus.req1_ready;
    assign resp_ready_dono = dono_q ? bus.resp1_ready : bus.resp0_ready;

    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        dono_d      = dono_q;
        ultimo_d    = ultimo_q;
        control_d   = control_q;
        valor1_d    = valor1_q;
        valor2_d    = valor2_q;
        resultado_d = resultado_q;
        desvio_d    = desvio_q;
        case (estado_q)
            OCIOSO: begin
                if (aceite0 || aceite1) begin
                    dono_d     = aceite1;
                    ultimo_d   = aceite1;
                    control_d  = aceite1 ? bus.req1_op : bus.req0_op;
                    valor1_d   = aceite1 ? bus.req1_a : bus.req0_a;
                    valor2_d   = aceite1 ? bus.req1_b : bus.req0_b;
                    contador_d = CW'(LATENCIA - 1);
                    estado_d   = EXECUTA;
                end
            end
            EXECUTA: begin
                if (contador_q == '0) begin
                    resultado_d = alu_resultado;
                    desvio_d    = alu_desvio;
                    estado_d    = RESPONDE;
                end else begin
                    contador_d = contador_q - 1'b1;
                end
            end
            RESPONDE: begin
                if (resp_ready_dono) begin
                    control_d = OP_NOP;
                    estado_d  = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            contador_q  <= '0;
            dono_q      <= 1'b0;
            ultimo_q    <= 1'b1;
            control_q   <= OP_NOP;
            valor1_q    <= '0;
            valor2_q    <= '0;
            resultado_q <= '0;
            desvio_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            dono_q      <= dono_d;
            ultimo_q    <= ultimo_d;
            control_q   <= control_d;
            valor1_q    <= valor1_d;
            valor2_q    <= valor2_d;
            resultado_q <= resultado_d;
            desvio_q    <= desvio_d;
        end
    end

    assign alu_control        = control_q;
    assign alu_valor1         = valor1_q;
    assign alu_valor2         = valor2_q;
    assign bus.resp_resultado = resultado_q;
    assign bus.resp_desvio    = desvio_q;
    assign bus.resp0_valid    = (estado_q == RESPONDE) && !dono_q;
    assign bus.resp1_valid    = (estado_q == RESPONDE) && dono_q;

`ifdef ARBITRO_ALU_CONTADORES_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cont0_q;
    logic [15:0] cont1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cont0_q <= '0;
            cont1_q <= '0;
        end else begin
            if (aceite0) cont0_q <= sat_inc(cont0_q);
            if (aceite1) cont1_q <= sat_inc(cont1_q);
        end
    end

    assign cont_grant0 = cont0_q;
    assign cont_grant1 = cont1_q;
`endif

endmodule

// File: tb/tb_arbitro_alu.sv
// Self-checking bench for arbitro_alu: vector table, alternation, stall,
// reset-abort and randomized traffic against a behavioural model.
module tb_arbitro_alu;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  alu_control;
    logic [31:0] alu_valor1;
    logic [31:0] alu_valor2;
    logic [31:0] alu_resultado;
    logic        alu_desvio;
`ifdef ARBITRO_ALU_CONTADORES_EN
    logic [15:0] cont_grant0;
    logic [15:0] cont_grant1;
`endif

    arbitro_alu_if #(.DATA_W(32)) bus ();

    arbitro_alu #(.DATA_W(32), .LATENCIA(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .alu_control   (alu_control),
        .alu_valor1    (alu_valor1),
        .alu_valor2    (alu_valor2),
        .alu_resultado (alu_resultado),
        .alu_desvio    (alu_desvio)
`ifdef ARBITRO_ALU_CONTADORES_EN
        ,
        .cont_grant0   (cont_grant0),
        .cont_grant1   (cont_grant1)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural ALU: and, or, add, shift-left, subtract; anything else gives 0.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a << b[4:0];
            4'b0110: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_resultado = alu_fn(alu_control, alu_valor1, alu_valor2);
        alu_desvio    = (alu_valor1 == alu_valor2);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Requester model: pending payloads, expected responses, round-robin memory.
    logic        pend  [2];
    logic [3:0]  p_op  [2];
    logic [31:0] p_a   [2];
    logic [31:0] p_b   [2];
    logic [31:0] exp_r [2];
    logic        exp_d [2];
    int          last_grant = 1;
    int          grants [2] = '{0, 0};

    task automatic drive_reqs();
        bus.req0_valid = pend[0];
        bus.req0_op    = p_op[0];
        bus.req0_a     = p_a[0];
        bus.req0_b     = p_b[0];
        bus.req1_valid = pend[1];
        bus.req1_op    = p_op[1];
        bus.req1_a     = p_a[1];
        bus.req1_b     = p_b[1];
    endtask

    task automatic arm(input int n, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        pend[n]  = 1'b1;
        p_op[n]  = op;
        p_a[n]   = a;
        p_b[n]   = b;
        exp_r[n] = alu_fn(op, a, b);
        exp_d[n] = (a == b);
    endtask

    function automatic logic resp_v(input int n);
        return (n == 1) ? bus.resp1_valid : bus.resp0_valid;
    endfunction

    task automatic set_rr(input logic r0, input logic r1);
        bus.resp0_ready = r0;
        bus.resp1_ready = r1;
    endtask

    // Called at a negedge with requests driven; runs one full transaction.
    task automatic serve(input int hold, output int who);
        int cyc;
        int exp_who;
        int lat;
        logic [3:0]  op;
        logic [31:0] a, b, er;
        logic ed;
        who = -1;
        cyc = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && cyc < 20) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        if (!(bus.req0_ready || bus.req1_ready)) begin
            chk("grant_timeout", 32'd1, 32'd0);
            return;
        end
        exp_who = (pend[0] && pend[1]) ? 1 - last_grant : (pend[1] ? 1 : 0);
        who     = bus.req1_ready ? 1 : 0;
        chk("grant_who", who, exp_who);
        chk("ready_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
        op = p_op[who];
        a  = p_a[who];
        b  = p_b[who];
        er = exp_r[who];
        ed = exp_d[who];
        @(posedge clock);
        last_grant = who;
        grants[who]++;
        @(negedge clock);
        pend[who] = 1'b0;
        drive_reqs();
        lat = 0;
        while (!resp_v(who) && lat < 20) begin
            chk("busy_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            chk("alu_ops_held", {alu_control == op, alu_valor1 == a, alu_valor2 == b}, 3'b111);
            @(negedge clock);
            lat++;
        end
        chk("latency", lat, LAT);
        if (!resp_v(who)) return;
        set_rr(1'b0, 1'b0);
        if (who == 0) bus.resp1_ready = 1'b1;
        else          bus.resp0_ready = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clock);
            chk("resp_owner_valid", resp_v(who), 1'b1);
            chk("resp_other_valid", resp_v(1 - who), 1'b0);
            chk("resultado", bus.resp_resultado, er);
            chk("desvio", bus.resp_desvio, ed);
            chk("stall_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        if (who == 0) set_rr(1'b1, 1'b0);
        else          set_rr(1'b0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        set_rr(1'b0, 1'b0);
        chk("resp_cleared", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
        chk("alu_control_idle", alu_control, 4'hF);
    endtask

    typedef struct {
        int          who;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        d;
        int          hold;
        bit          both;
    } vec_t;

    vec_t tab [8];
    int   order [4] = '{0, 1, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w2;
        tab[0] = '{0, 4'b0010, 32'd5,      32'd7,      32'd12,         1'b0, 0, 1'b0};
        tab[1] = '{1, 4'b0011, 32'd1,      32'd4,      32'd16,         1'b0, 5, 1'b1};
        tab[2] = '{0, 4'b0110, 32'd3,      32'd3,      32'd0,          1'b1, 1, 1'b0};
        tab[3] = '{1, 4'b0110, 32'd3,      32'd4,      32'hFFFFFFFF,   1'b0, 0, 1'b0};
        tab[4] = '{0, 4'b0000, 32'hF0F0,   32'hFF00,   32'hF000,       1'b0, 2, 1'b0};
        tab[5] = '{1, 4'b1010, 32'd9,      32'd9,      32'd0,          1'b1, 0, 1'b0};
        tab[6] = '{0, 4'b0001, 32'h0F0,    32'h00F,    32'h0FF,        1'b0, 0, 1'b0};
        tab[7] = '{1, 4'b1111, 32'd7,      32'd8,      32'd0,          1'b0, 1, 1'b0};

        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; p_op[n] = 4'd0; p_a[n] = 32'd0; p_b[n] = 32'd0;
            exp_r[n] = 32'd0; exp_d[n] = 1'b0;
        end
        drive_reqs();
        set_rr(1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        chk("rst_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
        chk("rst_resultado", bus.resp_resultado, 32'd0);
        chk("rst_desvio", bus.resp_desvio, 1'b0);
        chk("rst_alu_control", alu_control, 4'hF);
        chk("rst_alu_valores", {alu_valor1, alu_valor2} == 64'd0, 1'b1);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            arm(tab[i].who, tab[i].op, tab[i].a, tab[i].b);
            exp_r[tab[i].who] = tab[i].r;
            exp_d[tab[i].who] = tab[i].d;
            if (tab[i].both) begin
                arm(1 - tab[i].who, 4'b0010, 32'd1, 32'd1);
                exp_r[1 - tab[i].who] = 32'd2;
                exp_d[1 - tab[i].who] = 1'b1;
            end
            drive_reqs();
            serve(tab[i].hold, w);
            chk("table_who", w, tab[i].who);
            if (tab[i].both) begin
                serve(0, w2);
                chk("table_second_who", w2, 1 - tab[i].who);
            end
        end

        // Both requesting continuously alternates 0,1,0,1
        arm(0, 4'b0010, 32'd10, 32'd20);
        arm(1, 4'b0010, 32'd30, 32'd40);
        drive_reqs();
        for (int k = 0; k < 4; k++) begin
            serve(0, w);
            chk("alternation", w, order[k]);
            if (k < 3 && w >= 0) arm(w, 4'b0010, 32'(k), 32'd100);
            drive_reqs();
        end

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 2) != 0) begin
                    logic [3:0]  op;
                    logic [31:0] a, b;
                    case ($urandom_range(0, 5))
                        0: op = 4'b0000;
                        1: op = 4'b0001;
                        2: op = 4'b0010;
                        3: op = 4'b0011;
                        4: op = 4'b0110;
                        default: op = 4'($urandom_range(0, 15));
                    endcase
                    a = $urandom;
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    arm(n, op, a, b);
                end
            end
            if (!pend[0] && !pend[1]) arm(0, 4'b0010, $urandom, $urandom);
            drive_reqs();
            serve($urandom_range(0, 3), w);
        end

        // Reset during EXECUTA aborts the transaction
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        arm(0, 4'b0010, 32'd100, 32'd23);
        drive_reqs();
        #1;
        chk("abort_setup_ready", bus.req0_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        pend[0] = 1'b0;
        drive_reqs();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
        chk("abort_resultado", bus.resp_resultado, 32'd0);
        chk("abort_desvio", bus.resp_desvio, 1'b0);
        chk("abort_alu_control", alu_control, 4'hF);
        chk("abort_alu_valores", {alu_valor1, alu_valor2} == 64'd0, 1'b1);
        arm(0, 4'b0010, 32'd2, 32'd3);
        arm(1, 4'b0110, 32'd9, 32'd4);
        drive_reqs();
        #1;
        chk("abort_ready_in_reset", {bus.req0_ready, bus.req1_ready}, 2'b00);
        @(negedge clock);
        reset      = 1'b0;
        last_grant = 1;
        grants[0]  = 0;
        grants[1]  = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            chk("abort_no_resp", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
            if (c == 0) begin
                serve(0, w);
                chk("post_reset_first", w, 0);
            end
        end
        serve(0, w);
        chk("post_reset_second", w, 1);

        // Three req0 and two req1 transfers since reset
        arm(0, 4'b0001, 32'd1, 32'd2);
        drive_reqs();
        serve(0, w);
        arm(0, 4'b0001, 32'd4, 32'd8);
        arm(1, 4'b0000, 32'd5, 32'd5);
        drive_reqs();
        serve(1, w);
        serve(0, w);
        chk("model_grants", {grants[0][15:0], grants[1][15:0]}, {16'd3, 16'd2});
`ifdef ARBITRO_ALU_CONTADORES_EN
        chk("cont_grant0", cont_grant0, 32'(grants[0]));
        chk("cont_grant1", cont_grant1, 32'(grants[1]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
